vram_pixel_writer: RTL and testbench

Write-side front end of the video index RAM. Accepts computed Mandelbrot pixel results (x, y, iteration count) over a valid/ready stream and maps each iteration count to an 8-bit colour index. Converts (x, y) to a linear frame-buffer address and issues one RAM write per enabled cycle through a small FIFO. Also performs full-screen clears and signals frame completion; its outputs drive the write port of the synchronous video pipeline's index RAM.

---
 rtl/video_pkg.sv | 33 +++
 rtl/fifo_sync_generic.sv | 55 +++++
 rtl/vram_pixel_writer.sv | 161 ++++++++++++++++
 tb/tb_vram_pixel_writer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants and the iteration-count to colour-index mapping.
// The mapping function is also used by the CLUT generator scripts, so its
// behaviour must stay in step with them.
package video_pkg;

    localparam int H_ACTIVE_DEF     = 640;
    localparam int V_ACTIVE_DEF     = 480;
    localparam int FRAME_PIXELS_DEF = H_ACTIVE_DEF * V_ACTIVE_DEF;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_CLEAR
    } wr_state_t;

    // Index 0 marks "in set"; any escaping pixel whose low bits happen to be
    // zero is nudged to 1 so it never looks like an in-set pixel.
    function automatic logic [31:0] iter_to_index(input logic [31:0] iter,
                                                  input logic [31:0] max_iter,
                                                  input int unsigned idx_w);
        logic [31:0] mask;
        logic [31:0] idx;
        mask = (idx_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << idx_w) - 32'd1);
        idx  = iter & mask;
        if (iter >= max_iter) begin
            idx = '0;
        end else if (idx == '0) begin
            idx = 32'd1;
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_sync_generic.sv
// Single-clock show-ahead FIFO. The head entry is always visible on dout;
// push and pop only take effect on cycles where en is high.
module fifo_sync_generic #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = en && push && !full;
    assign do_pop  = en && pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // Read and write pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vram_pixel_writer.sv
// Write-side front end of the video index RAM: turns Mandelbrot pixel results
// into colour-index writes, performs full-screen clears and flags frame
// completion. Everything advances only on clk_en cycles.
module vram_pixel_writer
    import video_pkg::*;
#(
    parameter int MAW      = 19,
    parameter int MDW      = 8,
    parameter int IW       = 12,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int FD       = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en,
    input  logic           clr_req,
    input  logic [MDW-1:0] clr_color,
    output logic           clr_busy,
    input  logic           px_valid,
    output logic           px_ready,
    input  logic [XW-1:0]  px_x,
    input  logic [YW-1:0]  px_y,
    input  logic [IW-1:0]  px_iter,
    input  logic [IW-1:0]  max_iter,
    output logic           vram_we,
    output logic [MAW-1:0] vram_adr_w,
    output logic [MDW-1:0] vram_dat_w,
    output logic           frame_done,
    output logic           err_oob
);

    localparam int              FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam logic [MAW-1:0]  LAST_ADR     = MAW'(FRAME_PIXELS - 1);

    wr_state_t          state;
    wr_state_t          state_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic [MAW+MDW-1:0] fifo_din;
    logic [MAW+MDW-1:0] fifo_dout;
    logic [MAW-1:0]     fifo_adr;
    logic [MDW-1:0]     fifo_dat;
    logic [MAW-1:0]     pix_adr;
    logic [MDW-1:0]     pix_idx;
    logic [MAW-1:0]     clr_cnt;
    logic [MAW-1:0]     frame_cnt;
    logic               in_range;
    logic               transfer;
    logic               clr_last;

    assign px_ready  = (state == ST_RUN) && !fifo_full;
    assign clr_busy  = (state != ST_RUN);
    assign transfer  = clk_en && px_valid && px_ready;
    assign in_range  = ({1'b0, px_x} < (XW+1)'(H_ACTIVE)) &&
                       ({1'b0, px_y} < (YW+1)'(V_ACTIVE));
    assign pix_adr   = MAW'(px_y) * MAW'(H_ACTIVE) + MAW'(px_x);
    assign pix_idx   = MDW'(iter_to_index(32'(px_iter), 32'(max_iter), MDW));
    assign fifo_din  = {pix_adr, pix_idx};
    assign fifo_push = px_valid && px_ready && in_range;
    assign {fifo_adr, fifo_dat} = fifo_dout;
    assign clr_last  = (state == ST_CLEAR) && (clr_cnt == LAST_ADR);

    fifo_sync_generic #(
        .DW    (MAW + MDW),
        .DEPTH (FD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (clk_en),
        .push  (fifo_push),
        .pop   (!fifo_empty),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic: a clear first drains queued pixels, then sweeps the screen.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (clr_req)    state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty) state_next = ST_CLEAR;
            ST_CLEAR: if (clr_last)   state_next = ST_RUN;
            default:                  state_next = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    // Clear address counter, walking every pixel address once per clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (clk_en && (state == ST_CLEAR)) begin
            clr_cnt <= clr_last ? '0 : clr_cnt + MAW'(1);
        end
    end

    // Registered RAM write port: clear data takes priority, otherwise the FIFO head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_we    <= 1'b0;
            vram_adr_w <= '0;
            vram_dat_w <= '0;
        end else if (clk_en) begin
            if (state == ST_CLEAR) begin
                vram_we    <= 1'b1;
                vram_adr_w <= clr_cnt;
                vram_dat_w <= clr_color;
            end else if (!fifo_empty) begin
                vram_we    <= 1'b1;
                vram_adr_w <= fifo_adr;
                vram_dat_w <= fifo_dat;
            end else begin
                vram_we    <= 1'b0;
            end
        end
    end

    // Frame counter: only pixel writes issued in RUN count; the pulse lines up with the last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else if (clk_en) begin
            frame_done <= 1'b0;
            if (clr_last) begin
                frame_cnt <= '0;
            end else if ((state == ST_RUN) && !fifo_empty) begin
                if (frame_cnt == LAST_ADR) begin
                    frame_cnt  <= '0;
                    frame_done <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + MAW'(1);
                end
            end
        end
    end

    // Sticky flag for pixels that were accepted but fell outside the screen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_oob <= 1'b0;
        end else if (transfer && !in_range) begin
            err_oob <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Self-checking bench for vram_pixel_writer. A reduced screen height keeps
// full clears and full frames short while keeping the real 640-pixel line.
module tb_vram_pixel_writer;

    localparam int MAW = 19, MDW = 8, IW = 12, XW = 10, YW = 9, FD = 4;
    localparam int H = 640;
    localparam int V = 4;
    localparam int FRAME = H * V;

    logic           clk = 1'b0;
    logic           rst;
    logic           clk_en;
    logic           clr_req;
    logic [MDW-1:0] clr_color;
    logic           clr_busy;
    logic           px_valid;
    logic           px_ready;
    logic [XW-1:0]  px_x;
    logic [YW-1:0]  px_y;
    logic [IW-1:0]  px_iter;
    logic [IW-1:0]  max_iter;
    logic           vram_we;
    logic [MAW-1:0] vram_adr_w;
    logic [MDW-1:0] vram_dat_w;
    logic           frame_done;
    logic           err_oob;

    vram_pixel_writer #(
        .MAW(MAW), .MDW(MDW), .IW(IW), .XW(XW), .YW(YW),
        .H_ACTIVE(H), .V_ACTIVE(V), .FD(FD)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy),
        .px_valid(px_valid), .px_ready(px_ready),
        .px_x(px_x), .px_y(px_y), .px_iter(px_iter), .max_iter(max_iter),
        .vram_we(vram_we), .vram_adr_w(vram_adr_w), .vram_dat_w(vram_dat_w),
        .frame_done(frame_done), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    typedef struct {
        int adr;
        int dat;
        bit is_clear;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  busy_m;
    bit  clear_started;
    int  gap_cnt;
    int  frame_cnt_m;
    bit  err_m;
    bit  last_we_m;
    bit  last_fd_m;
    int  last_adr_m;
    int  last_dat_m;
    int  fd_exp;
    int  fd_obs;

    // Any run that overshoots this is stuck.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int exp_index(input int iter, input int mx);
        if (iter >= mx) return 0;
        if ((iter % 256) == 0) return 1;
        return iter % 256;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        busy_m        = 1'b0;
        clear_started = 1'b0;
        gap_cnt       = 0;
        frame_cnt_m   = 0;
        err_m         = 1'b0;
        last_we_m     = 1'b0;
        last_fd_m     = 1'b0;
        last_adr_m    = 0;
        last_dat_m    = 0;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_we"}, vram_we, 0);
        checkOutput({tag, "_adr"}, vram_adr_w, 0);
        checkOutput({tag, "_dat"}, vram_dat_w, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
        checkOutput({tag, "_err_oob"}, err_oob, 0);
        checkOutput({tag, "_clr_busy"}, clr_busy, 0);
        checkOutput({tag, "_px_ready"}, px_ready, 1);
    endtask

    // Reference model step for one clock edge, given the inputs that were applied before it.
    task automatic model_edge(input bit en, input bit valid, input int x, input int y,
                              input int it, input int mx, input bit clr, input int color);
        bit  was_busy;
        bit  exp_fd;
        wr_t w;
        was_busy = busy_m;
        exp_fd   = 1'b0;
        if (!en) begin
            checkOutput("hold_we", vram_we, last_we_m);
            checkOutput("hold_adr", vram_adr_w, last_adr_m);
            checkOutput("hold_dat", vram_dat_w, last_dat_m);
            checkOutput("hold_frame_done", frame_done, last_fd_m);
        end else begin
            if (exp_q.size() == 0) begin
                checkOutput("we_idle", vram_we, 0);
                last_we_m = 1'b0;
            end else if (exp_q[0].is_clear && !clear_started && vram_we !== 1'b1) begin
                gap_cnt++;
                checkOutput("clear_start_gap", gap_cnt <= 2, 1);
                last_we_m = 1'b0;
            end else begin
                w = exp_q.pop_front();
                checkOutput("we", vram_we, 1);
                checkOutput("adr", vram_adr_w, w.adr);
                checkOutput("dat", vram_dat_w, w.dat);
                last_we_m  = 1'b1;
                last_adr_m = w.adr;
                last_dat_m = w.dat;
                if (w.is_clear) begin
                    clear_started = 1'b1;
                    if (exp_q.size() == 0) begin
                        busy_m        = 1'b0;
                        clear_started = 1'b0;
                        gap_cnt       = 0;
                        frame_cnt_m   = 0;
                    end
                end else if (!was_busy) begin
                    frame_cnt_m++;
                    if (frame_cnt_m == FRAME) begin
                        frame_cnt_m = 0;
                        exp_fd      = 1'b1;
                    end
                end
            end
            if (!last_we_m) begin
                checkOutput("idle_adr_held", vram_adr_w, last_adr_m);
                checkOutput("idle_dat_held", vram_dat_w, last_dat_m);
            end
            checkOutput("frame_done", frame_done, exp_fd);
            last_fd_m = exp_fd;
            if (exp_fd) fd_exp++;
            if (frame_done === 1'b1) fd_obs++;
            if (valid && !was_busy) begin
                if (x < H && y < V) begin
                    exp_q.push_back('{adr: y * H + x, dat: exp_index(it, mx), is_clear: 1'b0});
                end else begin
                    err_m = 1'b1;
                end
            end
            if (clr && !was_busy) begin
                busy_m = 1'b1;
                for (int i = 0; i < FRAME; i++) begin
                    exp_q.push_back('{adr: i, dat: color, is_clear: 1'b1});
                end
            end
        end
        checkOutput("err_oob", err_oob, err_m);
        checkOutput("clr_busy", clr_busy, busy_m);
        checkOutput("px_ready", px_ready, !busy_m);
    endtask

    // Drive one cycle's inputs, clock it, then check the result against the model.
    task automatic applyStimulus(input bit en, input bit valid, input int x, input int y,
                                 input int it, input int mx, input bit clr, input int color);
        clk_en    = en;
        px_valid  = valid;
        px_x      = XW'(x);
        px_y      = YW'(y);
        px_iter   = IW'(it);
        max_iter  = IW'(mx);
        clr_req   = clr;
        clr_color = MDW'(color);
        @(posedge clk);
        #1;
        model_edge(en, valid, x, y, it, mx, clr, color);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
    endtask

    initial begin
        rst       = 1'b1;
        clk_en    = 1'b0;
        clr_req   = 1'b0;
        clr_color = '0;
        px_valid  = 1'b0;
        px_x      = '0;
        px_y      = '0;
        px_iter   = '0;
        max_iter  = '0;
        fd_exp    = 0;
        fd_obs    = 0;
        model_reset();
        #12;
        check_reset_values("reset");
        rst = 1'b0;

        // First pixel: latency of one enabled edge with an empty FIFO.
        applyStimulus(1'b1, 1'b1, 3, 2, 5, 100, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        checkOutput("first_px_we", vram_we, 1);
        checkOutput("first_px_adr", vram_adr_w, 1283);
        checkOutput("first_px_dat", vram_dat_w, 5);

        // Index mapping boundaries, back to back.
        applyStimulus(1'b1, 1'b1, 10, 0, 100, 100, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 11, 0, 256, 1000, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 12, 0, 257, 1000, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 13, 1, 255, 1000, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 639, 3, 0, 5, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 0, 3, 4095, 4095, 1'b0, 0);
        idle(2);

        // Out-of-range coordinates are swallowed and flagged.
        applyStimulus(1'b1, 1'b1, 640, 0, 9, 50, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 5, 4, 9, 50, 1'b0, 0);
        idle(2);
        checkOutput("oob_sticky", err_oob, 1);

        // Burst of 8 pixels with the clock enable toggling every cycle.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(i[0] == 1'b0, 1'b1, 100 + i / 2, 1, 20 + i / 2, 200, 1'b0, 0);
        end
        idle(2);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int x;
            int y;
            x = ($urandom_range(0, 15) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639);
            y = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 511) : $urandom_range(0, 3);
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, x, y,
                          $urandom_range(0, 4095), $urandom_range(1, 4095), 1'b0, 0);
        end

        // Clear requested while a pixel is being accepted; extra requests mid-clear are ignored.
        applyStimulus(1'b1, 1'b1, 7, 2, 33, 90, 1'b0, 0);
        applyStimulus(1'b1, 1'b1, 8, 2, 34, 90, 1'b1, 8'hA5);
        for (int i = 0; i < 6000 && busy_m; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, 1'b1, 1, 1, 1, 2,
                          (i >= 10 && i < 14), 8'hA5);
        end
        checkOutput("clear_finished", clr_busy, 0);
        idle(2);

        // One full frame of pixels must give exactly one frame_done pulse.
        fd_exp = 0;
        fd_obs = 0;
        for (int i = 0; i < 6000 && fd_exp == 0; i++) begin
            int x;
            x = ($urandom_range(0, 19) == 0) ? 700 : $urandom_range(0, 639);
            applyStimulus($urandom_range(0, 9) != 0, 1'b1, x, $urandom_range(0, 3),
                          $urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0, 0);
        end
        idle(3);
        checkOutput("frame_pulses", fd_obs, 1);

        // Reset in the middle of a clear.
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 8'h3C);
        for (int i = 0; i < 3000 && !(clear_started && last_adr_m >= 1000); i++) begin
            applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 8'h3C);
        end
        checkOutput("reached_adr_1000", last_adr_m, 1000);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid_clear");
        #10;
        check_reset_values("rst_held");
        rst = 1'b0;
        model_reset();
        applyStimulus(1'b1, 1'b1, 10, 3, 7, 50, 1'b0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        checkOutput("post_reset_adr", vram_adr_w, 1930);
        checkOutput("post_reset_dat", vram_dat_w, 7);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
